// File: rtl/ascon_pack.sv
// Shared types for the Ascon permutation control path:
// FSM state encoding and mode_i encodings.
package ascon_pack;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_P12  = 2'b00;
  localparam logic [1:0] MODE_P6   = 2'b01;
  localparam logic [1:0] MODE_P8   = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

endpackage

// File: rtl/permutation_controller.sv
// Round sequencer for the Ascon permutation datapath.
// Macro ASCON_P8_EN enables the p8 mode (mode_i = 10).
module permutation_controller
  import ascon_pack::*;
#(
  parameter logic [3:0] LAST_ROUND = 4'd11
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [1:0] mode_i,
  input  logic       hold_i,
  output logic       sel_o,
  output logic       en_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic [3:0] first;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    first = LAST_ROUND - 4'd11;
    unique case (1'b1)
      mode_i == MODE_P6: first = LAST_ROUND - 4'd5;
`ifdef ASCON_P8_EN
      mode_i == MODE_P8: first = LAST_ROUND - 4'd7;
      mode_i == MODE_P12,
      mode_i == MODE_RSVD: ;
`else
      mode_i == MODE_P12,
      mode_i == MODE_P8,
      mode_i == MODE_RSVD: ;
`endif
      default: ;
    endcase

    state_nx = state;
    cnt_nx   = cnt;
    sel_o    = 1'b1;
    en_o     = 1'b0;
    round_o  = '0;
    busy_o   = 1'b0;
    done_o   = 1'b0;

    unique case (1'b1)
      state == RUN: begin
        busy_o  = 1'b1;
        round_o = cnt;
        if (!hold_i) begin
          en_o   = 1'b1;
          cnt_nx = cnt + 4'd1;
          if (cnt == LAST_ROUND)
            state_nx = DONE;
        end
      end
      default: begin
        done_o = (state == DONE);
        // Mode only matters here; afterwards the counter carries it
        if (start_i) begin
          sel_o    = 1'b0;
          en_o     = 1'b1;
          round_o  = first;
          cnt_nx   = first + 4'd1;
          state_nx = (first == LAST_ROUND) ? DONE : RUN;
        end else begin
          state_nx = IDLE;
        end
      end
    endcase

    if (!resetb_i) begin
      sel_o   = 1'b0;
      en_o    = 1'b0;
      round_o = '0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_permutation_controller.sv
// Table-driven bench with an expected-output scoreboard
// for permutation_controller.
module tb_permutation_controller;

  logic       clock_i  = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i  = 1'b0;
  logic [1:0] mode_i   = 2'b00;
  logic       hold_i   = 1'b0;
  logic       sel_o;
  logic       en_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  typedef struct packed {
    logic       sel;
    logic       en;
    logic [3:0] round;
    logic       busy;
    logic       done;
  } out_t;

  typedef struct {
    string      name;
    logic       start;
    logic [1:0] mode;
    logic       hold;
    out_t       exp;
  } vec_t;

  vec_t  vecs[$];
  out_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

`ifdef ASCON_P8_EN
  localparam int P8_FIRST = 4;
`else
  localparam int P8_FIRST = 0;
`endif

  always #5 clock_i = ~clock_i;

  permutation_controller dut (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .hold_i  (hold_i),
    .sel_o   (sel_o),
    .en_o    (en_o),
    .round_o (round_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  function automatic out_t o_idle();
    return '{1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
  endfunction

  function automatic out_t o_done();
    return '{1'b1, 1'b0, 4'd0, 1'b0, 1'b1};
  endfunction

  function automatic out_t o_zero();
    return '{1'b0, 1'b0, 4'd0, 1'b0, 1'b0};
  endfunction

  function automatic out_t o_acc(int r);
    logic [3:0] r4 = r[3:0];
    return '{1'b0, 1'b1, r4, 1'b0, 1'b0};
  endfunction

  function automatic out_t o_run(int r, logic en);
    logic [3:0] r4 = r[3:0];
    return '{1'b1, en, r4, 1'b1, 1'b0};
  endfunction

  task automatic add(string nm, logic st, logic [1:0] md,
                     logic hd, out_t e);
    vec_t v;
    v.name  = nm;
    v.start = st;
    v.mode  = md;
    v.hold  = hd;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  task automatic check(string nm, out_t e);
    out_t a;
    a = '{sel_o, en_o, round_o, busy_o, done_o};
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got sel=%b en=%b round=%0d busy=%b done=%b, want sel=%b en=%b round=%0d busy=%b done=%b",
               nm, a.sel, a.en, a.round, a.busy, a.done,
               e.sel, e.en, e.round, e.busy, e.done);
    end
  endtask

  task automatic run_vecs();
    foreach (vecs[i]) begin
      @(posedge clock_i);
      #1;
      start_i = vecs[i].start;
      mode_i  = vecs[i].mode;
      hold_i  = vecs[i].hold;
      exp_q.push_back(vecs[i].exp);
      name_q.push_back(vecs[i].name);
      @(negedge clock_i);
      check(name_q.pop_front(), exp_q.pop_front());
    end
    vecs.delete();
  endtask

  task automatic add_p12(string nm);
    add({nm, "_acc"}, 1'b1, 2'b00, 1'b0, o_acc(0));
    for (int r = 1; r <= 11; r++)
      add({nm, "_run"}, 1'b0, 2'b00, 1'b0, o_run(r, 1'b1));
    add({nm, "_done"}, 1'b0, 2'b00, 1'b0, o_done());
    add({nm, "_idle"}, 1'b0, 2'b00, 1'b0, o_idle());
  endtask

  initial begin
    #2;
    check("reset_outputs", o_zero());
    start_i = 1'b1;
    #1;
    check("reset_start_ignored", o_zero());
    start_i = 1'b0;
    @(posedge clock_i);
    #1;
    resetb_i = 1'b1;

    add("idle_after_reset", 1'b0, 2'b00, 1'b0, o_idle());
    add_p12("p12");

    add("p6_acc", 1'b1, 2'b01, 1'b0, o_acc(6));
    for (int r = 7; r <= 11; r++)
      add("p6_run_mode_chg", (r == 8), 2'b00, 1'b0,
          o_run(r, 1'b1));
    add("p6_done", 1'b0, 2'b10, 1'b0, o_done());
    add("p6_idle", 1'b0, 2'b00, 1'b0, o_idle());

    add("hold_acc", 1'b1, 2'b00, 1'b0, o_acc(0));
    for (int r = 1; r <= 4; r++)
      add("hold_pre", 1'b0, 2'b00, 1'b0, o_run(r, 1'b1));
    for (int k = 0; k < 3; k++)
      add("hold_stall", 1'b0, 2'b00, 1'b1, o_run(5, 1'b0));
    for (int r = 5; r <= 11; r++)
      add("hold_post", 1'b0, 2'b00, 1'b0, o_run(r, 1'b1));
    add("hold_done_c15", 1'b0, 2'b00, 1'b0, o_done());
    add("hold_idle", 1'b0, 2'b00, 1'b0, o_idle());

    add("b2b_acc", 1'b1, 2'b01, 1'b0, o_acc(6));
    for (int r = 7; r <= 11; r++)
      add("b2b_run1", 1'b1, 2'b01, 1'b0, o_run(r, 1'b1));
    add("b2b_done_acc", 1'b1, 2'b01, 1'b0,
        '{1'b0, 1'b1, 4'd6, 1'b0, 1'b1});
    for (int r = 7; r <= 11; r++)
      add("b2b_run2", 1'b1, 2'b01, 1'b0, o_run(r, 1'b1));
    add("b2b_done2", 1'b0, 2'b01, 1'b0, o_done());
    add("b2b_idle", 1'b0, 2'b01, 1'b0, o_idle());

    add("cfg_acc", 1'b1, 2'b10, 1'b0, o_acc(P8_FIRST));
    for (int r = P8_FIRST + 1; r <= 11; r++)
      add("cfg_run", 1'b0, 2'b10, 1'b0, o_run(r, 1'b1));
    add("cfg_done", 1'b0, 2'b10, 1'b0, o_done());
    add("cfg_idle", 1'b0, 2'b10, 1'b0, o_idle());

    add("rsvd_acc", 1'b1, 2'b11, 1'b0, o_acc(0));
    add("rsvd_run", 1'b0, 2'b11, 1'b0, o_run(1, 1'b1));

    run_vecs();

    for (int r = 2; r <= 11; r++)
      add("rsvd_run", 1'b0, 2'b11, 1'b0, o_run(r, 1'b1));
    add("rsvd_done", 1'b0, 2'b11, 1'b0, o_done());

    add("rst_acc", 1'b1, 2'b00, 1'b0, o_acc(0));
    for (int r = 1; r <= 7; r++)
      add("rst_pre", 1'b0, 2'b00, 1'b0, o_run(r, 1'b1));
    run_vecs();

    #1;
    resetb_i = 1'b0;
    #1;
    check("rst_async_outputs", o_zero());
    @(posedge clock_i);
    #1;
    check("rst_held", o_zero());
    @(posedge clock_i);
    #1;
    resetb_i = 1'b1;

    for (int k = 0; k < 3; k++)
      add("rst_no_done", 1'b0, 2'b00, 1'b0, o_idle());
    add_p12("rst_p12");
    run_vecs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/permutation_controller.md
PERMUTATION_CONTROLLER -- requirements
Module: permutation_controller

Interface
REQ-001 The block SHALL have parameter LAST_ROUND, default 4'd11, meaning the round-constant index of the final round of every permutation.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clock_i and resetb_i.
REQ-003 Port clock_i SHALL be an input, 1 bit, the rising-edge clock.
REQ-004 Port resetb_i SHALL be an input, 1 bit, the asynchronous active-low reset.
REQ-005 Port start_i SHALL be an input, 1 bit, a request to run one permutation.
REQ-006 Port mode_i SHALL be an input, 2 bits: 00 = p12, 01 = p6, 10 = p8, 11 = reserved.
REQ-007 Port hold_i SHALL be an input, 1 bit, which stalls a running permutation.
REQ-008 Port sel_o SHALL be an output, 1 bit, the datapath mux select: 0 = external state_i, 1 = fed-back register.
REQ-009 Port en_o SHALL be an output, 1 bit, the datapath state-register enable.
REQ-010 Port round_o SHALL be an output, 4 bits, the round-constant index to the constant-addition stage.
REQ-011 Port busy_o SHALL be an output, 1 bit, high while a permutation is in progress.
REQ-012 Port done_o SHALL be an output, 1 bit, a one-cycle pulse marking that the final round result is in the register.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 The first round index SHALL be LAST_ROUND+1-N, with N = 12 for p12, 6 for p6 and 8 for p8; the reserved mode SHALL be treated as p12.
REQ-015 In IDLE or DONE with start_i=1, the block SHALL accept the request that cycle: sel_o=0, en_o=1, round_o=first round (combinational from mode_i), counter loads first+1, and next state is RUN.
REQ-016 If the first round equals LAST_ROUND, the next state after acceptance SHALL be DONE.
REQ-017 In RUN with hold_i=0, the block SHALL drive sel_o=1, en_o=1 and round_o=counter, and increment the counter.
REQ-018 In RUN with hold_i=0 and counter==LAST_ROUND, the next state SHALL be DONE.
REQ-019 In RUN with hold_i=1, the block SHALL drive en_o=0, keep sel_o=1, and hold both the counter and the state.
REQ-020 In RUN, start_i SHALL be ignored and mode_i SHALL be ignored, because the mode is latched at acceptance.
REQ-021 done_o SHALL be 1 only in DONE, which lasts exactly one cycle; the next state SHALL be IDLE unless REQ-015 applies (back-to-back operation).
REQ-022 busy_o SHALL be 1 in RUN and 0 in IDLE and DONE.
REQ-023 Latency: with no holds, done_o SHALL be asserted exactly N cycles after the acceptance cycle, with en_o high for exactly N cycles; each hold cycle SHALL add one cycle.
REQ-024 Outside the acceptance cycle and RUN, the block SHALL drive en_o=0, sel_o=1 and round_o=0.

Reset
REQ-025 Asserting resetb_i low SHALL force IDLE and counter=0, and SHALL force sel_o=0, en_o=0, round_o=0, busy_o=0 and done_o=0 immediately, independent of the clock.
REQ-026 A reset during RUN SHALL abandon the permutation with no done_o pulse.
REQ-027 The first start_i sampled after reset release SHALL be accepted normally.

Configuration
REQ-028 The p8 feature SHALL be controlled by macro ASCON_P8_EN.
REQ-029 With ASCON_P8_EN defined, mode 10 SHALL run p8 with first round 4.
REQ-030 Without ASCON_P8_EN, mode 10 SHALL be treated as p12, and the p8 decode logic SHALL be absent.

Structure
REQ-031 The FSM state enum and the mode encodings SHALL be defined in ascon_pack.
REQ-032 The block SHALL have no sub-modules; one always_ff block SHALL hold the state and counter, and one always_comb block SHALL produce the outputs and next-state.

Verification
REQ-033 Scenario p12: start_i=1 with mode_i=00 for one cycle, no hold -> round_o = 0,1,...,11 on 12 consecutive en_o cycles, sel_o=0 only on the first, done_o pulses in cycle 12, busy_o high in cycles 1-11.
REQ-034 Scenario p6: start_i=1 with mode_i=01 -> round_o = 6..11, done_o in cycle 6; mode_i changed mid-run has no effect.
REQ-035 Scenario hold: a p12 run with hold_i=1 for 3 cycles while round_o=5 -> en_o low for those 3 cycles, round_o stays 5, done_o in cycle 15.
REQ-036 Scenario back-to-back: start_i held high with mode_i=01 -> the DONE cycle also accepts (sel_o=0, round_o=6), the second done_o arrives 6 cycles later, and there is no IDLE gap.
REQ-037 Scenario reset: resetb_i pulsed low while round_o=7 -> all outputs go to 0 asynchronously, no done_o, and a subsequent start runs a full p12.
REQ-038 Scenario config: mode_i=10 with ASCON_P8_EN -> rounds 4..11 and done_o in cycle 8; without the macro -> rounds 0..11.
